// File: rtl/synth_bus_pkg.sv
// Shared encodings for the synth data bus RAM peripheral: bus direction,
// control register offsets, STATUS/CMD bit positions and controller states.
package synth_bus_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_PTR    = 2'd1;
    localparam logic [1:0] REG_STREAM = 2'd2;

    // STATUS read bits and CMD write bits share the low two positions.
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_OVR_BIT    = 1;
    localparam int CMD_CLEAR_BIT   = 0;
    localparam int CMD_CLR_OVR_BIT = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MEM,
        SEL_STATUS,
        SEL_PTR,
        SEL_STREAM
    } sel_e;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, read-before-write, registered read data.
module ram_sp #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_ram_ctrl.sv
// Bus RAM peripheral: direct window, auto-incrementing stream port and a
// hardware clear engine sharing one single-port RAM.
module bus_ram_ctrl
    import synth_bus_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH_LOG2 = 8,
    parameter logic [ADDR_W-1:0] BASE       = 16'h8000,
    parameter logic [ADDR_W-1:0] CTRL_BASE  = 16'h7FF0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Strobe,
    input  logic              ReadWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              DataOE,
    output logic              Busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // One extra bit so BASE+DEPTH cannot wrap at the top of the address map.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(DEPTH);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  ovr_q, ovr_d;
    logic                  vld_q, vld_d;
    logic                  rd_ram_q, rd_ram_d;
    logic [DATA_W-1:0]     rd_reg_q, rd_reg_d;

    sel_e                  sel;
    logic                  acc;
    logic [DEPTH_LOG2-1:0] off;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata, ram_rdata;

    assign Busy = (state_q == ST_CLEAR);
    assign acc  = Strobe && !Busy;
    assign off  = DEPTH_LOG2'(Address - BASE);

    always_comb begin
        sel = SEL_NONE;
        if (({1'b0, Address} >= WIN_LO) && ({1'b0, Address} < WIN_HI))
            sel = SEL_MEM;
        else if (Address == CTRL_BASE + ADDR_W'(REG_STATUS))
            sel = SEL_STATUS;
        else if (Address == CTRL_BASE + ADDR_W'(REG_PTR))
            sel = SEL_PTR;
        else if (Address == CTRL_BASE + ADDR_W'(REG_STREAM))
            sel = SEL_STREAM;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ovr_d     = ovr_q;
        vld_d     = 1'b0;
        rd_ram_d  = 1'b0;
        rd_reg_d  = '0;
        ram_we    = 1'b0;
        ram_addr  = (sel == SEL_STREAM) ? ptr_q : off;
        ram_wdata = DataIn;

        if (Strobe && Busy) ovr_d = 1'b1;

        // Clear engine owns the RAM port while busy; bus requests are dropped.
        if (Busy) begin
            ram_we    = 1'b1;
            ram_addr  = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + DEPTH_LOG2'(1);
            if (cnt_q == DEPTH_LOG2'(DEPTH - 1)) state_d = ST_IDLE;
        end

        if (acc) begin
            vld_d = (ReadWrite == RW_READ);
            case (sel)
                SEL_MEM, SEL_STREAM: begin
                    ram_we   = (ReadWrite == RW_WRITE);
                    rd_ram_d = (ReadWrite == RW_READ);
                    if (sel == SEL_STREAM) ptr_d = ptr_q + DEPTH_LOG2'(1);
                end
                SEL_STATUS: begin
                    if (ReadWrite == RW_WRITE) begin
                        if (DataIn[CMD_CLR_OVR_BIT]) ovr_d = 1'b0;
                        if (DataIn[CMD_CLEAR_BIT]) begin
                            state_d = ST_CLEAR;
                            cnt_d   = '0;
                        end
                    end else begin
                        rd_reg_d[STAT_BUSY_BIT] = Busy;
                        rd_reg_d[STAT_OVR_BIT]  = ovr_q;
                    end
                end
                SEL_PTR: begin
                    if (ReadWrite == RW_WRITE) ptr_d = DataIn[DEPTH_LOG2-1:0];
                    else                       rd_reg_d = DATA_W'(ptr_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            ptr_q    <= '0;
            ovr_q    <= 1'b0;
            vld_q    <= 1'b0;
            rd_ram_q <= 1'b0;
            rd_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            ovr_q    <= ovr_d;
            vld_q    <= vld_d;
            rd_ram_q <= rd_ram_d;
            rd_reg_q <= rd_reg_d;
        end
    end

    ram_sp #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Unmapped reads fall through to rd_reg_q, which is zero for them.
    assign DataOut   = rd_ram_q ? ram_rdata : rd_reg_q;
    assign DataValid = vld_q;
    assign DataOE    = vld_q;

endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Bench for bus_ram_ctrl: lockstep behavioural model of the 8-bit instance,
// plus a directed check of a 16-bit / 1024-word instance.
module tb_bus_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst, stb, rw;
    logic [15:0] addr, din;
    logic [7:0]  dout8;
    logic        vld8, oe8, busy8;
    logic        rst16, stb16;
    logic [15:0] dout16;
    logic        vld16, oe16, busy16;

    always #5 clk = ~clk;

    bus_ram_ctrl dut8 (
        .Clock(clk), .Reset(rst), .Strobe(stb), .ReadWrite(rw), .Address(addr),
        .DataIn(din[7:0]), .DataOut(dout8), .DataValid(vld8), .DataOE(oe8), .Busy(busy8)
    );

    bus_ram_ctrl #(.DATA_W(16), .DEPTH_LOG2(10)) dut16 (
        .Clock(clk), .Reset(rst16), .Strobe(stb16), .ReadWrite(rw), .Address(addr),
        .DataIn(din), .DataOut(dout16), .DataValid(vld16), .DataOE(oe16), .Busy(busy16)
    );

    // Reference model: memory image, pointer, sticky overrun, clear cycles left.
    logic [7:0] m_mem [256];
    logic [7:0] m_ptr;
    logic       m_ovr;
    int         busy_left;
    logic [7:0] last_rd;
    int         n_assert = 0;
    int         n_fail   = 0;
    string      phase    = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h, expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic       bb, acc, exp_v, start;
        logic [7:0] exp_d;
        int         a;
        bb = (busy_left > 0);
        acc = stb && !bb;
        exp_v = 1'b0; exp_d = 8'h00; start = 1'b0;
        a = int'(addr);
        if (stb && bb) m_ovr = 1'b1;
        if (acc) begin
            if (a >= 'h8000 && a < 'h8100) begin
                if (rw) m_mem[a - 'h8000] = din[7:0];
                else begin exp_v = 1'b1; exp_d = m_mem[a - 'h8000]; end
            end else if (a == 'h7FF0) begin
                if (rw) begin
                    if (din[1]) m_ovr = 1'b0;
                    start = din[0];
                end else begin
                    exp_v = 1'b1; exp_d = m_ovr ? 8'd2 : 8'd0;
                end
            end else if (a == 'h7FF1) begin
                if (rw) m_ptr = din[7:0];
                else begin exp_v = 1'b1; exp_d = m_ptr; end
            end else if (a == 'h7FF2) begin
                if (rw) m_mem[m_ptr] = din[7:0];
                else begin exp_v = 1'b1; exp_d = m_mem[m_ptr]; end
                m_ptr = m_ptr + 8'd1;
            end else if (!rw) begin
                exp_v = 1'b1;
            end
        end
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        if (start) begin
            busy_left = 256;
            foreach (m_mem[i]) m_mem[i] = 8'h00;
        end
        #1;
        stb = 1'b0;
        chk("busy",  32'(busy8), 32'(busy_left > 0));
        chk("valid", 32'(vld8),  32'(exp_v));
        chk("oe",    32'(oe8),   32'(exp_v));
        if (exp_v) begin
            chk("rdata", 32'(dout8), 32'(exp_d));
            last_rd = dout8;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        stb = 1'b1; rw = 1'b1; addr = a; din = d;
        cycle();
    endtask

    task automatic rd(input logic [15:0] a);
        stb = 1'b1; rw = 1'b0; addr = a;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Called at a sample point; releases reset at a later sample point.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        chk("rst_dout",  32'(dout8), 32'h0);
        chk("rst_valid", 32'(vld8),  32'h0);
        chk("rst_oe",    32'(oe8),   32'h0);
        chk("rst_busy",  32'(busy8), 32'h1);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 8'h00; m_ovr = 1'b0; busy_left = 256;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
    endtask

    task automatic acc16(input logic w, input logic [15:0] a, input logic [15:0] d);
        stb16 = 1'b1; rw = w; addr = a; din = d;
        @(posedge clk); #1;
        stb16 = 1'b0;
    endtask

    initial begin
        int         n;
        int         k;
        logic [7:0] va, vb, vc;
        rst = 1'b1; rst16 = 1'b1; stb = 1'b0; stb16 = 1'b0;
        rw = 1'b0; addr = 16'h0; din = 16'h0; last_rd = 8'h00;
        m_ptr = 8'h00; m_ovr = 1'b0; busy_left = 256;
        @(posedge clk); #1;

        phase = "t1_reset_clear";
        do_reset(2);
        idle(256);
        for (int i = 0; i < 256; i++) rd(16'h8000 + 16'(i));

        phase = "t2_direct";
        wr(16'h8001, 16'h05);
        wr(16'h8002, 16'h01);
        rd(16'h8001); chk("rd8001", 32'(last_rd), 32'h05);
        rd(16'h8002); chk("rd8002", 32'(last_rd), 32'h01);
        wr(16'h8000, 16'hA5); wr(16'h80FF, 16'h3C);
        rd(16'h8000); rd(16'h80FF); rd(16'h8001);

        phase = "t3_stream";
        va = 8'($urandom); vb = 8'($urandom); vc = 8'($urandom);
        wr(16'h7FF1, 16'hFE);
        wr(16'h7FF2, {8'h0, va}); wr(16'h7FF2, {8'h0, vb}); wr(16'h7FF2, {8'h0, vc});
        wr(16'h7FF1, 16'hFE);
        rd(16'h7FF2); chk("strmA", 32'(last_rd), 32'(va));
        rd(16'h7FF2); chk("strmB", 32'(last_rd), 32'(vb));
        rd(16'h7FF2); chk("strmC", 32'(last_rd), 32'(vc));
        rd(16'h7FF1); chk("ptr_wrap", 32'(last_rd), 32'h01);
        rd(16'h80FF); rd(16'h8000);

        phase = "t4_cmd_clear";
        wr(16'h7FF0, 16'h01);
        wr(16'h8001, 16'h77);
        idle(5);
        wr(16'h7FF0, 16'h01);
        idle(260);
        rd(16'h8001); chk("rd8001_cleared", 32'(last_rd), 32'h00);
        rd(16'h7FF0); chk("status_ovr", 32'(last_rd), 32'h02);
        wr(16'h7FF0, 16'h02);
        rd(16'h7FF0); chk("status_clr", 32'(last_rd), 32'h00);

        phase = "t5_unmapped";
        wr(16'h8010, 16'h99); wr(16'h7FF1, 16'h10);
        rd(16'h1234); chk("rd1234", 32'(last_rd), 32'h00);
        wr(16'h1234, 16'hFF); wr(16'h7FFF, 16'hEE); wr(16'h8100, 16'hDD); wr(16'h7FF3, 16'h03);
        rd(16'h7FFF); rd(16'h8100); rd(16'h7FF3);
        rd(16'h7FF1); rd(16'h7FF0); rd(16'h7FF2); rd(16'h8010);

        phase = "t6_reset_mid_clear";
        wr(16'h8020, 16'h5A);
        wr(16'h7FF0, 16'h01);
        idle(100);
        do_reset(3);
        idle(256);
        rd(16'h8020); rd(16'h7FF1); chk("ptr_after_rst", 32'(last_rd), 32'h00);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 9));
            rw = 1'($urandom_range(0, 1));
            din = 16'($urandom);
            if (k <= 4) addr = 16'h8000 + 16'($urandom_range(0, 255));
            else if (k == 5) begin
                addr = 16'h7FF0;
                din = ($urandom_range(0, 15) == 0) ? 16'h1 : (din & 16'h2);
            end
            else if (k == 6) addr = 16'h7FF1;
            else if (k == 7) addr = 16'h7FF2;
            else if (k == 8) addr = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8100;
            else addr = 16'($urandom);
            stb = ($urandom_range(0, 3) != 0);
            cycle();
        end

        phase = "t7_wide";
        rst16 = 1'b0;
        n = 0;
        for (int i = 0; i < 2000 && busy16; i++) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_len", 32'(n), 32'd1024);
        chk("busy_done", 32'(busy16), 32'h0);
        acc16(1'b1, 16'h83FF, 16'hBEEF);
        acc16(1'b0, 16'h83FF, 16'h0);
        chk("v_beef", 32'(vld16), 32'h1);
        chk("oe_beef", 32'(oe16), 32'h1);
        chk("rd_beef", 32'(dout16), 32'hBEEF);
        acc16(1'b0, 16'h83FE, 16'h0);
        chk("rd_83fe", 32'(dout16), 32'h0);
        acc16(1'b1, 16'h7FF1, 16'hFFFF);
        acc16(1'b0, 16'h7FF1, 16'h0);
        chk("ptr_trunc", 32'(dout16), 32'h03FF);
        acc16(1'b0, 16'h7FF2, 16'h0);
        chk("strm_beef", 32'(dout16), 32'hBEEF);
        acc16(1'b0, 16'h8400, 16'h0);
        chk("v_unmapped", 32'(vld16), 32'h1);
        chk("rd_unmapped", 32'(dout16), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
